morse_round_ctrl: RTL and testbench

Parametrised Morse-code round controller for the two-player spy game. Player 1 keys a message of up to DEPTH letters into internal storage; player 2 then re-keys it, and each symbol and letter is scored as it arrives. It replaces the hard-wired 10-bit / 16-address player/RAM arrangement with generic symbol width and message depth. All timing derives from one clock with a tick strobe; there are no derived clocks.

---
 rtl/morse_round_ctrl.sv | 230 +++++++++++++++++++++++
 tb/tb_morse_round_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/morse_round_ctrl.sv
// Morse round controller: player 1 keys a message into storage, player 2 re-keys it
// and every symbol and letter is scored against the stored copy as it arrives.
module morse_round_ctrl #(
    parameter int SYMS      = 5,
    parameter int DEPTH     = 16,
    parameter int ADDR_W    = 4,
    parameter int DOT_TICKS = 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                tick,
    input  logic                key,
    input  logic                next,
    input  logic                done,
    output logic [1:0]          state,
    output logic [ADDR_W:0]     letters,
    output logic [ADDR_W-1:0]   enter_addr,
    output logic [ADDR_W-1:0]   replay_addr,
    output logic [2*SYMS-1:0]   cur_word,
    output logic [2*SYMS-1:0]   ref_word,
    output logic                sym_valid,
    output logic                sym_ok,
    output logic                letter_done,
    output logic                letter_ok,
    output logic [ADDR_W:0]     mismatches,
    output logic                full,
    output logic                pass
);
    localparam int WORD_W = 2 * SYMS;
    localparam int CNT_W  = $clog2(DOT_TICKS + 2);
    localparam int SC_W   = $clog2(SYMS + 1);

    localparam logic [CNT_W-1:0] DOT_LIM   = CNT_W'(DOT_TICKS);
    localparam logic [SC_W-1:0]  SYM_LIM   = SC_W'(SYMS);
    localparam logic [ADDR_W:0]  DEPTH_LIM = (ADDR_W + 1)'(DEPTH);
    localparam logic [1:0]       SYM_DOT   = 2'b01;
    localparam logic [1:0]       SYM_DASH  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ENTER  = 2'd1,
        ST_REPLAY = 2'd2,
        ST_RESULT = 2'd3
    } state_t;

    state_t              st, st_nxt;
    logic                armed, armed_nxt;
    logic                in_press, in_press_nxt;
    logic [CNT_W-1:0]    press_cnt, press_cnt_nxt;
    logic [SC_W-1:0]     sym_cnt, sym_cnt_nxt;
    logic [WORD_W-1:0]   cur_word_nxt;
    logic [ADDR_W-1:0]   enter_addr_nxt, replay_addr_nxt;
    logic [ADDR_W:0]     letters_nxt, mismatches_nxt, answered;
    logic                full_nxt, pass_nxt;
    logic                sym_valid_nxt, sym_ok_nxt, letter_done_nxt, letter_ok_nxt;

    logic                emit, has_sym, word_match, mem_we;
    logic [1:0]          sym, ref_sym;
    logic [WORD_W-1:0]   word_app;
    logic [SC_W-1:0]     cnt_app;

    logic [WORD_W-1:0]   mem [DEPTH];

    assign state    = st;
    assign ref_word = mem[replay_addr];

    // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
    always_comb begin
        st_nxt          = st;
        armed_nxt       = armed;
        in_press_nxt    = in_press;
        press_cnt_nxt   = press_cnt;
        enter_addr_nxt  = enter_addr;
        replay_addr_nxt = replay_addr;
        letters_nxt     = letters;
        mismatches_nxt  = mismatches;
        full_nxt        = full;
        sym_valid_nxt   = 1'b0;
        sym_ok_nxt      = 1'b0;
        letter_done_nxt = 1'b0;
        letter_ok_nxt   = 1'b0;
        mem_we          = 1'b0;
        emit            = 1'b0;
        sym             = SYM_DOT;
        ref_sym         = 2'b00;
        word_app        = cur_word;
        cnt_app         = sym_cnt;
        answered        = {1'b0, replay_addr};

        // Only presses that begin while armed in a keying phase are timed.
        if (key) begin
            if (in_press) begin
                if (tick && press_cnt <= DOT_LIM)
                    press_cnt_nxt = press_cnt + 1'b1;
            end else if (armed && (st == ST_ENTER || st == ST_REPLAY)) begin
                in_press_nxt  = 1'b1;
                press_cnt_nxt = CNT_W'(tick);
            end
        end else begin
            armed_nxt     = 1'b1;
            in_press_nxt  = 1'b0;
            press_cnt_nxt = '0;
            emit          = in_press;
            sym           = (press_cnt <= DOT_LIM) ? SYM_DOT : SYM_DASH;
        end

        // A released symbol is appended before any commit sampled on the same edge.
        for (int i = 0; i < SYMS; i++) begin
            if (sym_cnt == SC_W'(i)) begin
                ref_sym = ref_word[2*i +: 2];
                if (emit)
                    word_app[2*i +: 2] = sym;
            end
        end
        if (emit && sym_cnt < SYM_LIM) begin
            cnt_app       = sym_cnt + 1'b1;
            sym_valid_nxt = 1'b1;
            sym_ok_nxt    = (st == ST_REPLAY) && (sym == ref_sym);
        end
        cur_word_nxt = word_app;
        sym_cnt_nxt  = cnt_app;
        has_sym      = (cnt_app != '0);
        word_match   = (word_app == ref_word);

        unique case (st)
            ST_IDLE: begin
                if (done)
                    st_nxt = ST_ENTER;
            end
            ST_ENTER: begin
                if ((next || done) && has_sym && !full) begin
                    mem_we         = 1'b1;
                    enter_addr_nxt = enter_addr + 1'b1;
                    letters_nxt    = letters + 1'b1;
                    full_nxt       = (letters_nxt == DEPTH_LIM);
                    cur_word_nxt   = '0;
                    sym_cnt_nxt    = '0;
                end
                if (done && letters_nxt != '0)
                    st_nxt = ST_REPLAY;
            end
            ST_REPLAY: begin
                if ((next || done) && has_sym) begin
                    letter_done_nxt = 1'b1;
                    letter_ok_nxt   = word_match;
                    mismatches_nxt  = mismatches + {{ADDR_W{1'b0}}, !word_match};
                    replay_addr_nxt = replay_addr + 1'b1;
                    answered        = {1'b0, replay_addr} + 1'b1;
                    cur_word_nxt    = '0;
                    sym_cnt_nxt     = '0;
                    if (answered == letters)
                        st_nxt = ST_RESULT;
                end
                // Giving up early scores every unanswered letter as wrong.
                if (done) begin
                    mismatches_nxt = mismatches_nxt + (letters - answered);
                    st_nxt         = ST_RESULT;
                end
            end
            ST_RESULT: begin
                if (done) begin
                    st_nxt          = ST_IDLE;
                    enter_addr_nxt  = '0;
                    replay_addr_nxt = '0;
                    letters_nxt     = '0;
                    mismatches_nxt  = '0;
                    full_nxt        = 1'b0;
                end
            end
            default: st_nxt = ST_IDLE;
        endcase

        // Any phase change disarms the key and empties the builder.
        if (st_nxt != st) begin
            armed_nxt     = 1'b0;
            in_press_nxt  = 1'b0;
            press_cnt_nxt = '0;
            cur_word_nxt  = '0;
            sym_cnt_nxt   = '0;
        end

        pass_nxt = (st_nxt == ST_RESULT) && (mismatches_nxt == '0);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            st          <= ST_IDLE;
            armed       <= 1'b0;
            in_press    <= 1'b0;
            press_cnt   <= '0;
            sym_cnt     <= '0;
            cur_word    <= '0;
            enter_addr  <= '0;
            replay_addr <= '0;
            letters     <= '0;
            mismatches  <= '0;
            full        <= 1'b0;
            pass        <= 1'b0;
            sym_valid   <= 1'b0;
            sym_ok      <= 1'b0;
            letter_done <= 1'b0;
            letter_ok   <= 1'b0;
        end else begin
            st          <= st_nxt;
            armed       <= armed_nxt;
            in_press    <= in_press_nxt;
            press_cnt   <= press_cnt_nxt;
            sym_cnt     <= sym_cnt_nxt;
            cur_word    <= cur_word_nxt;
            enter_addr  <= enter_addr_nxt;
            replay_addr <= replay_addr_nxt;
            letters     <= letters_nxt;
            mismatches  <= mismatches_nxt;
            full        <= full_nxt;
            pass        <= pass_nxt;
            sym_valid   <= sym_valid_nxt;
            sym_ok      <= sym_ok_nxt;
            letter_done <= letter_done_nxt;
            letter_ok   <= letter_ok_nxt;
        end
    end

    // NOTE: message storage is deliberately left out of reset so it can map onto plain RAM.
    always_ff @(posedge clock) begin
        if (mem_we)
            mem[enter_addr] <= word_app;
    end

endmodule

// File: tb/tb_morse_round_ctrl.sv
// Self-checking bench for morse_round_ctrl: directed rounds plus random rounds scored
// against a letter-list model of the game.
module tb_morse_round_ctrl;
    localparam int SYMS      = 5;
    localparam int DEPTH     = 16;
    localparam int ADDR_W    = 4;
    localparam int DOT_TICKS = 1;
    localparam int DOT       = 1;
    localparam int DASH      = 3;

    logic        clock;
    logic        reset, tick, key, next, done;
    logic [1:0]  state;
    logic [4:0]  letters, mismatches;
    logic [3:0]  enter_addr, replay_addr;
    logic [9:0]  cur_word, ref_word;
    logic        sym_valid, sym_ok, letter_done, letter_ok, full, pass;

    int vectors     = 0;
    int miscompares = 0;
    int exp_mis;
    int msg_sym [DEPTH][SYMS];
    int msg_len [DEPTH];

    morse_round_ctrl #(
        .SYMS(SYMS), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .DOT_TICKS(DOT_TICKS)
    ) dut (
        .clock(clock), .reset(reset), .tick(tick), .key(key), .next(next), .done(done),
        .state(state), .letters(letters), .enter_addr(enter_addr), .replay_addr(replay_addr),
        .cur_word(cur_word), .ref_word(ref_word), .sym_valid(sym_valid), .sym_ok(sym_ok),
        .letter_done(letter_done), .letter_ok(letter_ok), .mismatches(mismatches),
        .full(full), .pass(pass)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no end of stimulus, required completion");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, sample outputs 1 time unit after the edge.
    task automatic cyc(input logic k, input logic t, input logic n, input logic d);
        key = k; tick = t; next = n; done = d;
        @(posedge clock);
        #1;
        tick = 1'b0; next = 1'b0; done = 1'b0;
    endtask

    task automatic gap();
        cyc(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    endtask

    task automatic press(input int nticks, input int extra, input logic n, input logic d);
        for (int i = 0; i < nticks; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < extra; i++)  cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, n, d);
    endtask

    // A dot is any press seeing at most DOT_TICKS ticks; a dash sees more.
    task automatic press_sym(input int code, input logic n, input logic d);
        int nt, ex;
        if (code == DOT) nt = $urandom_range(0, DOT_TICKS);
        else             nt = $urandom_range(DOT_TICKS + 1, DOT_TICKS + 3);
        ex = $urandom_range(0, 2);
        if (nt + ex == 0) ex = 1;
        press(nt, ex, n, d);
    endtask

    function automatic logic [9:0] encode(input int idx);
        logic [9:0] w;
        w = '0;
        for (int i = 0; i < msg_len[idx]; i++) w = w | (10'(msg_sym[idx][i]) << (2 * i));
        return w;
    endfunction

    task automatic enter_letters(input int n);
        for (int l = 0; l < n; l++) begin
            msg_len[l] = $urandom_range(1, SYMS);
            for (int s = 0; s < msg_len[l]; s++)
                msg_sym[l][s] = ($urandom_range(0, 1) == 1) ? DASH : DOT;
        end
        gap();
        for (int l = 0; l < n; l++) begin
            logic with_release;
            with_release = 1'($urandom_range(0, 1));
            for (int s = 0; s < msg_len[l]; s++) begin
                press_sym(msg_sym[l][s], with_release && (s == msg_len[l] - 1), 1'b0);
                check("enter_sym_valid", sym_valid, 1);
            end
            if (!with_release) cyc(1'b0, 1'b0, 1'b1, 1'b0);
            check("enter_letters", letters, l + 1);
            check("enter_full", full, (l + 1 >= DEPTH));
            check("enter_cur_clear", cur_word, 0);
        end
    endtask

    task automatic replay_letter(input int idx, input logic corrupt);
        int   ans [SYMS];
        int   alen;
        gap();
        check("ref_word", ref_word, encode(idx));
        alen = msg_len[idx];
        for (int s = 0; s < alen; s++) ans[s] = msg_sym[idx][s];
        if (corrupt) begin
            if (alen < SYMS && $urandom_range(0, 1) == 1) begin
                ans[alen] = ($urandom_range(0, 1) == 1) ? DASH : DOT;
                alen++;
            end else begin
                int p;
                p = $urandom_range(0, alen - 1);
                ans[p] = 4 - ans[p];
            end
        end
        for (int s = 0; s < alen; s++) begin
            press_sym(ans[s], 1'b0, 1'b0);
            check("replay_sym_valid", sym_valid, 1);
            check("replay_sym_ok", sym_ok, (s < msg_len[idx]) && (ans[s] == msg_sym[idx][s]));
        end
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        check("letter_done", letter_done, 1);
        check("letter_ok", letter_ok, !corrupt);
        if (corrupt) exp_mis++;
        check("mismatches", mismatches, exp_mis);
    endtask

    initial begin
        int ext [6];
        logic [9:0] w5;
        int nlet, nans;

        reset = 1'b1; key = 1'b0; tick = 1'b0; next = 1'b0; done = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        check("rst_state", state, 0);
        check("rst_letters", letters, 0);
        check("rst_mismatches", mismatches, 0);
        check("rst_full", full, 0);
        check("rst_pass", pass, 0);
        check("rst_sym_valid", sym_valid, 0);
        check("rst_cur_word", cur_word, 0);

        // Defaults: dot(1 tick), dash(3 ticks), dot(1 tick), then an exact replay.
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        check("idle_to_enter", state, 1);
        gap();
        press(1, 0, 1'b0, 1'b0);
        check("def_sv0", sym_valid, 1);
        check("def_word0", cur_word, 10'h001);
        press(3, 0, 1'b0, 1'b0);
        check("def_word1", cur_word, 10'h00D);
        press(1, 0, 1'b0, 1'b0);
        check("def_word2", cur_word, 10'b00_00_01_11_01);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        check("def_letters", letters, 1);
        check("def_enter_addr", enter_addr, 1);
        check("def_mem0", ref_word, 10'b00_00_01_11_01);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        check("def_to_replay", state, 2);
        msg_len[0] = 3; msg_sym[0][0] = DOT; msg_sym[0][1] = DASH; msg_sym[0][2] = DOT;
        exp_mis = 0;
        replay_letter(0, 1'b0);
        check("def_result", state, 3);
        check("def_pass", pass, 1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        check("def_to_idle", state, 0);
        check("def_idle_letters", letters, 0);

        // Stored dot-dash, replayed dash-dash.
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        gap();
        press(1, 0, 1'b0, 1'b0);
        press(2, 0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        gap();
        press(2, 0, 1'b0, 1'b0);
        check("mm_sv0", sym_valid, 1);
        check("mm_ok0", sym_ok, 0);
        press(3, 0, 1'b0, 1'b0);
        check("mm_ok1", sym_ok, 1);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        check("mm_letter_ok", letter_ok, 0);
        check("mm_mismatches", mismatches, 1);
        check("mm_state", state, 3);
        check("mm_pass", pass, 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);

        // Early done: 3 letters, one answered correctly.
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        enter_letters(3);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        exp_mis = 0;
        replay_letter(0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        check("early_state", state, 3);
        check("early_mismatches", mismatches, 2);
        check("early_pass", pass, 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);

        // Overflow: fill all DEPTH slots, then a 17th letter of six presses.
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        enter_letters(DEPTH);
        w5 = '0;
        for (int i = 0; i < 6; i++) begin
            ext[i] = ($urandom_range(0, 1) == 1) ? DASH : DOT;
            if (i < SYMS) w5 = w5 | (10'(ext[i]) << (2 * i));
            press_sym(ext[i], 1'b0, 1'b0);
            check("ovf_sym_valid", sym_valid, (i < SYMS));
        end
        check("ovf_cur_word", cur_word, w5);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        check("ovf_letters", letters, DEPTH);
        check("ovf_full", full, 1);
        check("ovf_enter_addr", enter_addr, 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        check("ovf_to_replay", state, 2);
        check("ovf_builder_clear", cur_word, 0);
        exp_mis = 0;
        for (int k = 0; k < DEPTH; k++) replay_letter(k, 1'b0);
        check("ovf_result", state, 3);
        check("ovf_pass", pass, 1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        check("ovf_full_clear", full, 0);

        // Release in the same cycle as done; empty done with no letters is ignored.
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        gap();
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        check("sim_empty_done", state, 1);
        gap();
        press(3, 0, 1'b0, 1'b0);
        press(1, 0, 1'b0, 1'b1);
        check("sim_sv", sym_valid, 1);
        check("sim_state", state, 2);
        check("sim_letters", letters, 1);
        check("sim_mem0", ref_word, 10'h007);
        msg_len[0] = 2; msg_sym[0][0] = DASH; msg_sym[0][1] = DOT;
        exp_mis = 0;
        replay_letter(0, 1'b0);
        check("sim_pass", pass, 1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);

        // A key held across ENTER -> REPLAY is discarded on release.
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        gap();
        press(2, 0, 1'b1, 1'b0);
        check("hold_letters", letters, 1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        check("hold_state", state, 2);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check("hold_no_sym", sym_valid, 0);
        check("hold_cur_word", cur_word, 0);
        msg_len[0] = 1; msg_sym[0][0] = DASH;
        exp_mis = 0;
        replay_letter(0, 1'b0);
        check("hold_pass", pass, 1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);

        // Random rounds scored by the letter-list model.
        for (int r = 0; r < 6; r++) begin
            nlet = $urandom_range(1, 5);
            nans = $urandom_range(0, nlet);
            cyc(1'b0, 1'b0, 1'b0, 1'b1);
            check("rnd_enter", state, 1);
            enter_letters(nlet);
            cyc(1'b0, 1'b0, 1'b0, 1'b1);
            check("rnd_replay", state, 2);
            exp_mis = 0;
            for (int k = 0; k < nans; k++)
                replay_letter(k, 1'($urandom_range(0, 2) == 0));
            if (nans < nlet) begin
                check("rnd_still_replay", state, 2);
                cyc(1'b0, 1'b0, 1'b0, 1'b1);
                exp_mis += nlet - nans;
            end
            check("rnd_result", state, 3);
            check("rnd_mismatches", mismatches, exp_mis);
            check("rnd_pass", pass, (exp_mis == 0));
            cyc(1'b0, 1'b0, 1'b0, 1'b1);
            check("rnd_idle", state, 0);
        end

        // Reset mid-REPLAY with a press in progress.
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        enter_letters(3);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        exp_mis = 0;
        replay_letter(0, 1'b1);
        replay_letter(1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        reset = 1'b0;
        check("mrst_state", state, 0);
        check("mrst_mismatches", mismatches, 0);
        check("mrst_replay_addr", replay_addr, 0);
        check("mrst_letters", letters, 0);
        check("mrst_sym_valid", sym_valid, 0);
        check("mrst_letter_done", letter_done, 0);
        check("mrst_cur_word", cur_word, 0);
        check("mrst_pass", pass, 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check("mrst_release", sym_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
